fir_axilite_cfg: RTL and testbench
==================================

FIR_AXILITE_CFG -- requirements
Module: fir_axilite_cfg

Interface
REQ-001 SHALL have parameters: pADDR_WIDTH, default 12, AXI-lite and BRAM address width; pDATA_WIDTH, default 32, data width; Tape_Num, default 11, number of taps.
REQ-002 SHALL have these clock and reset ports:
- axis_clk  in  1  the single clock.
- axis_rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have these AXI-lite write ports:
- awaddr  in  pADDR_WIDTH  write address.
- awvalid  in  1  write-address valid.
- awready  out  1  write-address ready.
- wdata  in  pDATA_WIDTH  write data.
- wvalid  in  1  write-data valid.
- wready  out  1  write-data ready.
REQ-004 SHALL have these AXI-lite read ports:
- araddr  in  pADDR_WIDTH  read address.
- arvalid  in  1  read-address valid.
- arready  out  1  read-address ready.
- rdata  out  pDATA_WIDTH  read data.
- rvalid  out  1  read-data valid.
- rready  in  1  read-data ready.
REQ-005 SHALL have these tap BRAM ports:
- tap_WE  out  4  byte write enables.
- tap_EN  out  1  enable.
- tap_Di  out  pDATA_WIDTH  write data.
- tap_A  out  pADDR_WIDTH  byte address.
- tap_Do  in  pDATA_WIDTH  read data; synchronous, valid 1 cycle after EN.
REQ-006 SHALL have these core-side ports:
- ap_start_o  out  1  1-cycle start pulse.
- ap_done_i  in  1  1-cycle done pulse from the engine.
- data_length_o  out  32  programmed sample count.
- eng_tap_A  in  pADDR_WIDTH  engine tap read address.
- eng_tap_EN  in  1  engine tap read enable.

Function
REQ-007 SHALL decode this register map: 0x00 ap_ctrl (bit0 ap_start, bit1 ap_done, bit2 ap_idle); 0x10 data_length; 0x40+4k tap k for k=0..Tape_Num-1, mapped to tap_A=4k.
REQ-008 Write FSM SHALL have states W_ADDR, W_DATA and W_COMMIT:
- W_ADDR: awready=1; awaddr is latched on awvalid&&awready.
- W_DATA: wready=1; wdata is latched on wvalid&&wready; W_DATA waits indefinitely and accepts AW and W in separate, non-adjacent cycles.
- W_COMMIT: performs the register write or BRAM write (tap_EN=1, tap_WE=4'hF) in exactly 1 cycle, then returns to W_ADDR.
REQ-009 The block SHALL have no B channel; a write completes at W_COMMIT.
REQ-010 Read FSM SHALL have states R_ADDR, R_FETCH and R_VALID:
- R_ADDR: arready=1; araddr is latched on the handshake.
- R_FETCH: issues a BRAM read for a tap address; a register address is captured directly.
- R_VALID: rvalid=1 and rdata stable until rready, then returns to R_ADDR.
REQ-011 Read latency from the arvalid handshake to rvalid SHALL be 2 cycles with no BRAM conflict.
REQ-012 If W_COMMIT and R_FETCH both need the BRAM in the same cycle, the write SHALL win and R_FETCH SHALL hold 1 extra cycle.
REQ-013 Writing 1 to ap_start SHALL be accepted only when ap_idle=1; then ap_start_o pulses 1 cycle in the next cycle and ap_idle clears in that same cycle.
REQ-014 Writing 1 to ap_start while busy SHALL be ignored.
REQ-015 ap_start SHALL read back as 1 only during the pulse cycle.
REQ-016 ap_done_i SHALL set ap_done (sticky) and ap_idle in the same cycle.
REQ-017 A completed read of 0x00 (rvalid&&rready) SHALL clear ap_done; if ap_done_i arrives in that same cycle, set wins.
REQ-018 While ap_idle=0, tap_A and tap_EN SHALL come from eng_tap_A and eng_tap_EN, and tap_WE SHALL be 0.
REQ-019 While ap_idle=0, AXI tap writes and data_length writes SHALL be dropped, and AXI tap reads SHALL return 32'hFFFF_FFFF.
REQ-020 Writes to unmapped addresses SHALL be dropped; reads of unmapped addresses SHALL return 0.
REQ-021 Tap addresses at or above 0x40+4*Tape_Num SHALL be treated as unmapped.
REQ-022 Bits [31:3] of ap_ctrl SHALL read 0.

Reset
REQ-023 On axis_rst, both FSMs SHALL return to W_ADDR and R_ADDR, giving awready=1, arready=1, wready=0 and rvalid=0.
REQ-024 Reset SHALL set rdata=0, ap_start_o=0, ap_done=0, ap_idle=1, data_length_o=0, tap_EN=0, tap_WE=0, tap_A=0 and tap_Di=0.
REQ-025 Reset asserted mid-transaction SHALL abort the transaction with no BRAM write, and BRAM contents SHALL be preserved.

Structure
REQ-026 A shared package SHALL hold the register offsets (0x00, 0x10, 0x40), the ap_ctrl bit positions and the FSM state encodings.
REQ-027 There SHALL be no sub-modules; the tap BRAM stays external.

Verification
REQ-028 Write 0x10=600 with wvalid 3 cycles after the AW handshake; read 0x10 -> rdata=600 and data_length_o=600.
REQ-029 Write taps {0,-10,-9,23,56,63,56,23,-9,-10,0} to 0x40..0x68; read each back -> exact signed values; read 0x6C -> 0.
REQ-030 Write 0x00=1 while idle -> ap_start_o high for exactly 1 cycle and read 0x00 = 0x0; write 0x44=99 while busy -> readback after done = -10.
REQ-031 Pulse ap_done_i -> read 0x00 = 0x6, and a second read = 0x4.
REQ-032 Issue AR 0x48 in the cycle of a W_COMMIT to 0x4C -> rvalid 3 cycles after the AR handshake with rdata=-9; hold rready=0 for 5 cycles -> rdata stays stable.
REQ-033 Assert axis_rst during W_DATA of a tap write -> no tap_WE pulse, and read 0x00 = 0x4.

Source files
------------

// File: rtl/fir_axilite_cfg_pkg.sv
// Shared definitions for the FIR AXI-lite configuration block: register map,
// ap_ctrl bit positions and the write/read FSM state encodings.
package fir_axilite_cfg_pkg;

  localparam int unsigned ApCtrlOffset  = 32'h00;
  localparam int unsigned DataLenOffset = 32'h10;
  localparam int unsigned TapBaseOffset = 32'h40;

  localparam int unsigned ApStartBit = 0;
  localparam int unsigned ApDoneBit  = 1;
  localparam int unsigned ApIdleBit  = 2;

  typedef enum logic [1:0] {
    W_ADDR,
    W_DATA,
    W_COMMIT
  } w_state_e;

  typedef enum logic [1:0] {
    R_ADDR,
    R_FETCH,
    R_VALID
  } r_state_e;

  // True when addr selects one of the num_taps coefficient words.
  function automatic logic is_tap_addr(input logic [31:0] addr, input int unsigned num_taps);
    return (addr >= TapBaseOffset) && (addr < TapBaseOffset + 32'd4 * num_taps);
  endfunction

endpackage

// File: rtl/fir_axilite_cfg.sv
// AXI-lite configuration slave for the FIR engine: ap_ctrl, data_length and
// tap coefficient access through an external BRAM shared with the engine.
module fir_axilite_cfg
  import fir_axilite_cfg_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   ap_start_o,
  input  logic                   ap_done_i,
  output logic [31:0]            data_length_o,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  input  logic                   eng_tap_EN
);

  localparam logic [pADDR_WIDTH-1:0] CtrlAddr = pADDR_WIDTH'(ApCtrlOffset);
  localparam logic [pADDR_WIDTH-1:0] LenAddr  = pADDR_WIDTH'(DataLenOffset);
  localparam logic [pADDR_WIDTH-1:0] TapAddr  = pADDR_WIDTH'(TapBaseOffset);
  localparam logic [pADDR_WIDTH-1:0] WordMask = ~pADDR_WIDTH'(3);

  w_state_e               w_state_q, w_state_d;
  r_state_e               r_state_q, r_state_d;
  logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [pADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                   rd_phase_q, rd_phase_d;
  logic                   rd_bram_q, rd_bram_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   ap_start_q, ap_start_d;
  logic                   ap_done_q, ap_done_d;
  logic                   ap_idle_q, ap_idle_d;
  logic [31:0]            data_length_q, data_length_d;

  logic                   w_tap, w_is_ctrl, w_is_len, w_commit, w_bram;
  logic                   r_tap, r_is_ctrl, r_is_len, r_bram_req, r_bram_go;
  logic [pADDR_WIDTH-1:0] w_tap_off, r_tap_off;
  logic [pDATA_WIDTH-1:0] ap_ctrl_rd;

  assign w_tap     = is_tap_addr(32'(awaddr_q), Tape_Num);
  assign w_is_ctrl = (awaddr_q == CtrlAddr);
  assign w_is_len  = (awaddr_q == LenAddr);
  assign w_tap_off = (awaddr_q - TapAddr) & WordMask;
  assign w_commit  = (w_state_q == W_COMMIT);
  assign w_bram    = w_commit && w_tap && ap_idle_q;

  assign r_tap      = is_tap_addr(32'(araddr_q), Tape_Num);
  assign r_is_ctrl  = (araddr_q == CtrlAddr);
  assign r_is_len   = (araddr_q == LenAddr);
  assign r_tap_off  = (araddr_q - TapAddr) & WordMask;
  // The BRAM port has one user per cycle; a pending write commit takes it first.
  assign r_bram_req = (r_state_q == R_FETCH) && !rd_phase_q && r_tap && ap_idle_q;
  assign r_bram_go  = r_bram_req && !w_bram;

  assign awready       = (w_state_q == W_ADDR);
  assign wready        = (w_state_q == W_DATA);
  assign arready       = (r_state_q == R_ADDR);
  assign rvalid        = (r_state_q == R_VALID);
  assign rdata         = rdata_q;
  assign ap_start_o    = ap_start_q;
  assign data_length_o = data_length_q;

  always_comb begin
    ap_ctrl_rd             = '0;
    ap_ctrl_rd[ApStartBit] = ap_start_q;
    ap_ctrl_rd[ApDoneBit]  = ap_done_q;
    ap_ctrl_rd[ApIdleBit]  = ap_idle_q;
  end

  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    unique case (w_state_q)
      W_ADDR: begin
        if (awvalid) begin
          awaddr_d  = awaddr;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          wdata_d   = wdata;
          w_state_d = W_COMMIT;
        end
      end
      W_COMMIT: w_state_d = W_ADDR;
      default:  w_state_d = W_ADDR;
    endcase
  end

  always_comb begin
    r_state_d  = r_state_q;
    araddr_d   = araddr_q;
    rd_phase_d = rd_phase_q;
    rd_bram_d  = rd_bram_q;
    rdata_d    = rdata_q;
    unique case (r_state_q)
      R_ADDR: begin
        if (arvalid) begin
          araddr_d   = araddr;
          rd_phase_d = 1'b0;
          r_state_d  = R_FETCH;
        end
      end
      R_FETCH: begin
        if (!rd_phase_q) begin
          if (!(r_bram_req && w_bram)) begin
            rd_phase_d = 1'b1;
            rd_bram_d  = r_bram_req;
          end
        end else begin
          // tap_Do now carries the word addressed in the previous cycle.
          if (r_is_ctrl) begin
            rdata_d = ap_ctrl_rd;
          end else if (r_is_len) begin
            rdata_d = pDATA_WIDTH'(data_length_q);
          end else if (r_tap) begin
            rdata_d = rd_bram_q ? tap_Do : '1;
          end else begin
            rdata_d = '0;
          end
          rd_phase_d = 1'b0;
          r_state_d  = R_VALID;
        end
      end
      R_VALID: begin
        if (rready) r_state_d = R_ADDR;
      end
      default: r_state_d = R_ADDR;
    endcase
  end

  always_comb begin
    ap_start_d    = 1'b0;
    ap_done_d     = ap_done_q;
    ap_idle_d     = ap_idle_q;
    data_length_d = data_length_q;
    if (w_commit && ap_idle_q) begin
      if (w_is_ctrl && wdata_q[ApStartBit]) begin
        ap_start_d = 1'b1;
        ap_idle_d  = 1'b0;
      end
      if (w_is_len) data_length_d = 32'(wdata_q);
    end
    if (rvalid && rready && r_is_ctrl) ap_done_d = 1'b0;
    if (ap_done_i) begin
      ap_done_d = 1'b1;
      ap_idle_d = 1'b1;
    end
  end

  always_comb begin
    tap_WE = 4'h0;
    tap_EN = 1'b0;
    tap_Di = '0;
    tap_A  = '0;
    if (!ap_idle_q) begin
      tap_A  = eng_tap_A;
      tap_EN = eng_tap_EN;
    end else if (w_bram) begin
      tap_A  = w_tap_off;
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_Di = wdata_q;
    end else if (r_bram_go) begin
      tap_A  = r_tap_off;
      tap_EN = 1'b1;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      w_state_q     <= W_ADDR;
      r_state_q     <= R_ADDR;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      araddr_q      <= '0;
      rd_phase_q    <= 1'b0;
      rd_bram_q     <= 1'b0;
      rdata_q       <= '0;
      ap_start_q    <= 1'b0;
      ap_done_q     <= 1'b0;
      ap_idle_q     <= 1'b1;
      data_length_q <= '0;
    end else begin
      w_state_q     <= w_state_d;
      r_state_q     <= r_state_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
      araddr_q      <= araddr_d;
      rd_phase_q    <= rd_phase_d;
      rd_bram_q     <= rd_bram_d;
      rdata_q       <= rdata_d;
      ap_start_q    <= ap_start_d;
      ap_done_q     <= ap_done_d;
      ap_idle_q     <= ap_idle_d;
      data_length_q <= data_length_d;
    end
  end

endmodule

// File: tb/tb_fir_axilite_cfg.sv
// Directed self-checking bench for fir_axilite_cfg with a behavioural tap BRAM.
module tb_fir_axilite_cfg;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned NT = 11;

  logic          axis_clk = 1'b0;
  logic          axis_rst;
  logic [AW-1:0] awaddr, araddr, tap_A, eng_tap_A;
  logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata, tap_Di, tap_Do;
  logic [3:0]    tap_WE;
  logic          tap_EN, ap_start_o, ap_done_i, eng_tap_EN;
  logic [31:0]   data_length_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  int we_cnt  = 0;

  logic [31:0] bram [256];

  fir_axilite_cfg #(
    .pADDR_WIDTH(AW),
    .pDATA_WIDTH(DW),
    .Tape_Num   (NT)
  ) u_dut (
    .axis_clk     (axis_clk),
    .axis_rst     (axis_rst),
    .awaddr       (awaddr),
    .awvalid      (awvalid),
    .awready      (awready),
    .wdata        (wdata),
    .wvalid       (wvalid),
    .wready       (wready),
    .araddr       (araddr),
    .arvalid      (arvalid),
    .arready      (arready),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .rready       (rready),
    .tap_WE       (tap_WE),
    .tap_EN       (tap_EN),
    .tap_Di       (tap_Di),
    .tap_A        (tap_A),
    .tap_Do       (tap_Do),
    .ap_start_o   (ap_start_o),
    .ap_done_i    (ap_done_i),
    .data_length_o(data_length_o),
    .eng_tap_A    (eng_tap_A),
    .eng_tap_EN   (eng_tap_EN)
  );

  always #5 axis_clk = ~axis_clk;

  // Read-first synchronous BRAM.
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) bram[tap_A[9:2]] <= tap_Di;
      tap_Do <= bram[tap_A[9:2]];
    end
  end

  always @(posedge axis_clk) begin
    if (tap_WE != 4'h0) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input int gap);
    int n;
    @(negedge axis_clk);
    awaddr  = a;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin
      @(negedge axis_clk);
      n++;
    end
    if (!awready) check("aw_timeout", 32'(awready), 32'd1);
    @(negedge axis_clk);
    awvalid = 1'b0;
    repeat (gap - 1) @(negedge axis_clk);
    wdata  = d;
    wvalid = 1'b1;
    n = 0;
    while (!wready && n < 20) begin
      @(negedge axis_clk);
      n++;
    end
    if (!wready) check("w_timeout", 32'(wready), 32'd1);
    @(negedge axis_clk);
    wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output int lat);
    int n;
    @(negedge axis_clk);
    araddr  = a;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge axis_clk);
      n++;
    end
    if (!arready) check("ar_timeout", 32'(arready), 32'd1);
    @(negedge axis_clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      @(negedge axis_clk);
      lat++;
    end
    if (!rvalid) check("r_timeout", 32'(rvalid), 32'd1);
    d      = rdata;
    rready = 1'b1;
    @(negedge axis_clk);
    rready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          we0;
    int          taps [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    axis_rst   = 1'b1;
    awaddr     = '0;
    awvalid    = 1'b0;
    wdata      = '0;
    wvalid     = 1'b0;
    araddr     = '0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    ap_done_i  = 1'b0;
    eng_tap_A  = '0;
    eng_tap_EN = 1'b0;
    repeat (2) @(negedge axis_clk);

    check("rst_awready", 32'(awready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_start", 32'(ap_start_o), 32'd0);
    check("rst_len", data_length_o, 32'd0);
    check("rst_tap_en", 32'(tap_EN), 32'd0);
    check("rst_tap_we", 32'(tap_WE), 32'd0);
    check("rst_tap_a", 32'(tap_A), 32'd0);
    check("rst_tap_di", tap_Di, 32'd0);
    axis_rst = 1'b0;

    axi_write(12'h010, 32'd600, 3);
    axi_read(12'h010, rd, lat);
    check("len_rd", rd, 32'd600);
    check("len_lat", 32'(lat), 32'd2);
    check("len_out", data_length_o, 32'd600);

    for (int i = 0; i < int'(NT); i++) axi_write(AW'(32'h40 + 4 * i), 32'(taps[i]), 1);
    for (int i = 0; i < int'(NT); i++) begin
      axi_read(AW'(32'h40 + 4 * i), rd, lat);
      check($sformatf("tap%0d", i), rd, 32'(taps[i]));
    end
    check("tap_lat", 32'(lat), 32'd2);
    we0 = we_cnt;
    axi_write(12'h06C, 32'd5, 1);
    check("unmapped_we", 32'(we_cnt), 32'(we0));
    axi_read(12'h06C, rd, lat);
    check("unmapped_rd", rd, 32'd0);

    // Start the engine.
    axi_write(12'h000, 32'd1, 1);
    check("start_pre", 32'(ap_start_o), 32'd0);
    @(negedge axis_clk);
    check("start_pulse", 32'(ap_start_o), 32'd1);
    @(negedge axis_clk);
    check("start_post", 32'(ap_start_o), 32'd0);
    axi_read(12'h000, rd, lat);
    check("ctrl_busy", rd, 32'h0);
    eng_tap_A  = AW'(12'h020);
    eng_tap_EN = 1'b1;
    @(negedge axis_clk);
    check("eng_a", 32'(tap_A), 32'h20);
    check("eng_en", 32'(tap_EN), 32'd1);
    eng_tap_EN = 1'b0;
    we0 = we_cnt;
    axi_write(12'h044, 32'd99, 1);
    check("busy_we_commit", 32'(tap_WE), 32'd0);
    axi_write(12'h010, 32'd5, 1);
    check("busy_we_cnt", 32'(we_cnt), 32'(we0));
    axi_read(12'h044, rd, lat);
    check("busy_tap_rd", rd, 32'hFFFF_FFFF);
    axi_read(12'h010, rd, lat);
    check("busy_len_rd", rd, 32'd600);

    @(negedge axis_clk);
    ap_done_i = 1'b1;
    @(negedge axis_clk);
    ap_done_i = 1'b0;
    axi_read(12'h000, rd, lat);
    check("ctrl_done", rd, 32'h6);
    axi_read(12'h000, rd, lat);
    check("ctrl_clr", rd, 32'h4);
    axi_read(12'h044, rd, lat);
    check("tap1_kept", rd, 32'hFFFF_FFF6);

    // AR handshake on the same edge that enters W_COMMIT of a tap write.
    @(negedge axis_clk);
    awaddr  = 12'h04C;
    awvalid = 1'b1;
    check("cf_awready", 32'(awready), 32'd1);
    @(negedge axis_clk);
    awvalid = 1'b0;
    wdata   = 32'd23;
    wvalid  = 1'b1;
    araddr  = 12'h048;
    arvalid = 1'b1;
    check("cf_wready", 32'(wready), 32'd1);
    check("cf_arready", 32'(arready), 32'd1);
    @(negedge axis_clk);
    wvalid  = 1'b0;
    arvalid = 1'b0;
    check("cf_we", 32'(tap_WE), 32'hF);
    check("cf_a", 32'(tap_A), 32'h0C);
    lat = 0;
    while (!rvalid && lat < 20) begin
      @(negedge axis_clk);
      lat++;
    end
    check("cf_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("cf_hold_v", 32'(rvalid), 32'd1);
      check("cf_hold_d", rdata, 32'hFFFF_FFF7);
      @(negedge axis_clk);
    end
    rready = 1'b1;
    @(negedge axis_clk);
    rready = 1'b0;

    // Reset while a tap write sits in W_DATA.
    we0 = we_cnt;
    @(negedge axis_clk);
    awaddr  = 12'h040;
    awvalid = 1'b1;
    @(negedge axis_clk);
    awvalid = 1'b0;
    check("rst_mid_wready", 32'(wready), 32'd1);
    wdata    = 32'd77;
    wvalid   = 1'b1;
    axis_rst = 1'b1;
    repeat (2) @(negedge axis_clk);
    wvalid   = 1'b0;
    axis_rst = 1'b0;
    @(negedge axis_clk);
    check("rst_mid_we", 32'(we_cnt), 32'(we0));
    check("rst_mid_len", data_length_o, 32'd0);
    check("rst_mid_aw", 32'(awready), 32'd1);
    axi_read(12'h000, rd, lat);
    check("rst_mid_ctrl", rd, 32'h4);
    axi_read(12'h040, rd, lat);
    check("rst_mid_tap0", rd, 32'd0);
    axi_read(12'h048, rd, lat);
    check("rst_mid_tap2", rd, 32'hFFFF_FFF7);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
